// File: rtl/mult_axil_driver.sv
// mult_axil_driver: AXI4-Lite master that writes two operands to a multiplier slave and reads back the 64-bit product.
// Define MULT_AXIL_DRIVER_READBACK_EN to read back both operands and flag any mismatch in m_err.
module mult_axil_driver #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 32'h00000000
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [31:0]                   s_a,
    input  logic [31:0]                   s_b,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [63:0]                   m_prod,
    output logic                          m_err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_A  = C_BASE_ADDR;
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_B  = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(4);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_LO = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(8);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_HI = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(12);

`ifdef MULT_AXIL_DRIVER_READBACK_EN
    typedef enum logic [2:0] {IDLE, WA, WB, RA, RB, RLO, RHI, OUT} state_t;
`else
    typedef enum logic [2:0] {IDLE, WA, WB, RLO, RHI, OUT} state_t;
`endif

    state_t                          state_q;
    logic [31:0]                     a_q, b_q, wdata_q;
    logic [63:0]                     prod_q;
    logic                            err_q, mvalid_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
    logic                            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                            aw_done_q, w_done_q;
    logic                            aw_fin, w_fin, b_hs, r_hs, resp_err;

    // Handshake qualifiers; a phase's AW/W count as finished once their handshake has happened or is happening now.
    always_comb begin
        aw_fin   = aw_done_q || (awvalid_q && M_AXI_AWREADY);
        w_fin    = w_done_q || (wvalid_q && M_AXI_WREADY);
        b_hs     = bready_q && M_AXI_BVALID;
        r_hs     = rready_q && M_AXI_RVALID;
        resp_err = b_hs ? (M_AXI_BRESP >= 2'b10) : (r_hs && (M_AXI_RRESP >= 2'b10));
    end

    // Sequencer: one operand pair at a time through write, read and result phases, all outputs registered.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            wdata_q   <= '0;
            prod_q    <= '0;
            err_q     <= 1'b0;
            mvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (resp_err)
                err_q <= 1'b1;
            case (state_q)
                IDLE: if (s_valid) begin
                    a_q       <= s_a;
                    b_q       <= s_b;
                    err_q     <= 1'b0;
                    state_q   <= WA;
                    awaddr_q  <= ADDR_A;
                    wdata_q   <= s_a;
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                end
                WA, WB: begin
                    if (awvalid_q && M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && M_AXI_WREADY) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin && !bready_q)
                        bready_q <= 1'b1;
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        if (state_q == WA) begin
                            state_q   <= WB;
                            awaddr_q  <= ADDR_B;
                            wdata_q   <= b_q;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end else begin
`ifdef MULT_AXIL_DRIVER_READBACK_EN
                            state_q  <= RA;
                            araddr_q <= ADDR_A;
`else
                            state_q  <= RLO;
                            araddr_q <= ADDR_LO;
`endif
                            arvalid_q <= 1'b1;
                        end
                    end
                end
`ifdef MULT_AXIL_DRIVER_READBACK_EN
                RA, RB, RLO, RHI: begin
`else
                RLO, RHI: begin
`endif
                    if (arvalid_q && M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                    if (r_hs) begin
                        rready_q <= 1'b0;
                        case (state_q)
`ifdef MULT_AXIL_DRIVER_READBACK_EN
                            RA: begin
                                if (M_AXI_RDATA != a_q)
                                    err_q <= 1'b1;
                                state_q   <= RB;
                                araddr_q  <= ADDR_B;
                                arvalid_q <= 1'b1;
                            end
                            RB: begin
                                if (M_AXI_RDATA != b_q)
                                    err_q <= 1'b1;
                                state_q   <= RLO;
                                araddr_q  <= ADDR_LO;
                                arvalid_q <= 1'b1;
                            end
`endif
                            RLO: begin
                                prod_q[31:0] <= M_AXI_RDATA;
                                state_q      <= RHI;
                                araddr_q     <= ADDR_HI;
                                arvalid_q    <= 1'b1;
                            end
                            default: begin
                                prod_q[63:32] <= M_AXI_RDATA;
                                state_q       <= OUT;
                                mvalid_q      <= 1'b1;
                            end
                        endcase
                    end
                end
                OUT: if (m_ready) begin
                    mvalid_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready       = (state_q == IDLE) && !ARESET;
    assign m_valid       = mvalid_q;
    assign m_prod        = prod_q;
    assign m_err         = err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_mult_axil_driver.sv
// tb_mult_axil_driver: drives mult_axil_driver against a behavioural AXI4-Lite multiplier slave.
module tb_mult_axil_driver;
    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef MULT_AXIL_DRIVER_READBACK_EN
    localparam int LAT = 12;
    localparam bit RB_EN = 1'b1;
`else
    localparam int LAT = 8;
    localparam bit RB_EN = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        s_valid = 1'b0, s_ready;
    logic [31:0] s_a = '0, s_b = '0;
    logic        m_valid, m_ready = 1'b0, m_err;
    logic [63:0] m_prod;
    logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
    logic        M_AXI_BVALID = 1'b0, M_AXI_BREADY;
    logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RREADY;
    logic [31:0] M_AXI_RDATA = '0;
    logic        M_AXI_RVALID = 1'b0;

    int n_checks = 0, n_fail = 0;

    // Slave model state and observation logs
    logic [31:0] reg_a = '0, reg_b = '0, aw_addr_l = '0, w_data_l = '0;
    bit          aw_got = 0, w_got = 0, inject_bresp = 0, corrupt_b = 0;
    int          aw_delay = 0, aw_wait = 0, aw_hs = 0, w_hs = 0, awv_viol = 0, wv_viol = 0;
    logic [31:0] waddr_log[$], raddr_log[$];

    mult_axil_driver #(.C_M_AXI_ADDR_WIDTH(32), .C_BASE_ADDR(BASE)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_prod(m_prod), .m_err(m_err),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= aw_delay);
    assign M_AXI_WREADY  = 1'b1;
    assign M_AXI_ARREADY = 1'b1;

    // Register-mapped multiplier slave: responds one cycle after the completing handshake.
    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            M_AXI_BVALID <= 1'b0;
            M_AXI_RVALID <= 1'b0;
            aw_got = 0;
            w_got = 0;
            aw_wait = 0;
        end else begin
            if (M_AXI_AWVALID && aw_got) awv_viol++;
            if (M_AXI_WVALID && w_got) wv_viol++;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_got = 1;
                aw_addr_l = M_AXI_AWADDR;
                waddr_log.push_back(M_AXI_AWADDR - BASE);
                aw_hs++;
                aw_wait = 0;
            end else if (M_AXI_AWVALID) aw_wait++;
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_got = 1;
                w_data_l = M_AXI_WDATA;
                w_hs++;
            end
            if (aw_got && w_got) begin
                if (aw_addr_l - BASE == 0) reg_a = w_data_l;
                else if (aw_addr_l - BASE == 4) reg_b = w_data_l;
                M_AXI_BRESP  <= (inject_bresp && aw_addr_l - BASE == 4) ? 2'b10 : 2'b00;
                M_AXI_BVALID <= 1'b1;
                aw_got = 0;
                w_got = 0;
            end else if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
            if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
            if (M_AXI_ARVALID) begin
                logic [31:0] off;
                logic [63:0] p;
                off = M_AXI_ARADDR - BASE;
                p = 64'(reg_a) * 64'(reg_b);
                raddr_log.push_back(off);
                M_AXI_RRESP  <= 2'b00;
                M_AXI_RVALID <= 1'b1;
                M_AXI_RDATA  <= off == 0 ? reg_a : off == 4 ? (corrupt_b ? 32'hDEAD : reg_b) : off == 8 ? p[31:0] : p[63:32];
            end
        end
    end

    // Offers one operand pair and waits until the result is presented; ok clears on a timeout.
    task automatic run_seq(input logic [31:0] a, input logic [31:0] b, output logic [63:0] prod, output logic err, output int lat, output bit ok);
        int t;
        ok = 1;
        @(negedge ACLK);
        s_valid = 1; s_a = a; s_b = b;
        t = 0;
        while (!s_ready && t < 50) begin @(negedge ACLK); t++; end
        if (!s_ready) ok = 0;
        @(posedge ACLK);
        #1 s_valid = 0;
        lat = 0;
        while (lat < 200) begin
            @(posedge ACLK);
            lat++;
            #1;
            if (m_valid) break;
        end
        if (!m_valid) ok = 0;
        prod = m_prod;
        err = m_err;
    endtask

    task automatic finish_seq();
        m_ready = 1;
        @(posedge ACLK);
        #1 m_ready = 0;
    endtask

    task automatic test_reset();
        ARESET = 1;
        #2;
        n_checks++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY} !== 5'b0) begin n_fail++; $display("FAIL reset_axi got=%b exp=00000", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}); end
        n_checks++; if ({s_ready, m_valid, m_err} !== 3'b0 || m_prod !== 64'd0) begin n_fail++; $display("FAIL reset_stream got=%b prod=%h exp=000 prod=0", {s_ready, m_valid, m_err}, m_prod); end
        n_checks++; if (M_AXI_AWPROT !== 3'b0 || M_AXI_ARPROT !== 3'b0 || M_AXI_WSTRB !== 4'hF) begin n_fail++; $display("FAIL prot_strb got=%h %h %h exp=0 0 f", M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB); end
        repeat (2) @(posedge ACLK);
        @(negedge ACLK) ARESET = 0;
        #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_sready got=%b exp=1", s_ready); end
    endtask

    task automatic test_basic();
        logic [63:0] p; logic e; int lat; bit ok;
        run_seq(32'd3, 32'd5, p, e, lat, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got=0 exp=1"); end
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
        n_checks++; if (p !== 64'h0F || e !== 1'b0) begin n_fail++; $display("FAIL basic_result got=%h err=%b exp=%h err=0", p, e, 64'h0F); end
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL basic_sready_out got=%b exp=0", s_ready); end
        finish_seq();
        n_checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL basic_return got=%b%b exp=01", m_valid, s_ready); end
    endtask

    task automatic test_max_addr_order();
        logic [63:0] p; logic e; int lat; bit ok;
        logic [31:0] exp_w[$], exp_r[$];
        exp_w = '{32'h0, 32'h4};
        exp_r = RB_EN ? '{32'h0, 32'h4, 32'h8, 32'hC} : '{32'h8, 32'hC};
        waddr_log.delete(); raddr_log.delete();
        run_seq(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, e, lat, ok);
        finish_seq();
        n_checks++; if (!ok || p !== 64'hFFFF_FFFE_0000_0001 || e !== 1'b0) begin n_fail++; $display("FAIL max_result got=%h err=%b exp=fffffffe00000001 err=0", p, e); end
        n_checks++; if (waddr_log != exp_w) begin n_fail++; $display("FAIL write_addr_order got=%p exp=%p", waddr_log, exp_w); end
        n_checks++; if (raddr_log != exp_r) begin n_fail++; $display("FAIL read_addr_order got=%p exp=%p", raddr_log, exp_r); end
    endtask

    task automatic test_aw_delay();
        logic [63:0] p; logic e; int lat; bit ok;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        aw_delay = 3; aw_hs = 0; w_hs = 0; awv_viol = 0; wv_viol = 0;
        run_seq(a, b, p, e, lat, ok);
        finish_seq();
        aw_delay = 0;
        n_checks++; if (!ok || p !== 64'(a) * 64'(b)) begin n_fail++; $display("FAIL awdelay_result got=%h exp=%h", p, 64'(a) * 64'(b)); end
        n_checks++; if (aw_hs !== 2 || w_hs !== 2) begin n_fail++; $display("FAIL awdelay_hs_count got=aw%0d w%0d exp=aw2 w2", aw_hs, w_hs); end
        n_checks++; if (wv_viol !== 0 || awv_viol !== 0) begin n_fail++; $display("FAIL valid_after_hs got=w%0d aw%0d exp=0 0", wv_viol, awv_viol); end
    endtask

    task automatic test_bresp_err();
        logic [63:0] p; logic e; int lat; bit ok;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        inject_bresp = 1;
        run_seq(a, b, p, e, lat, ok);
        finish_seq();
        inject_bresp = 0;
        n_checks++; if (!ok || e !== 1'b1 || p !== 64'(a) * 64'(b)) begin n_fail++; $display("FAIL bresp_err got=err%b %h exp=err1 %h", e, p, 64'(a) * 64'(b)); end
        run_seq(32'd7, 32'd9, p, e, lat, ok);
        finish_seq();
        n_checks++; if (!ok || e !== 1'b0 || p !== 64'd63) begin n_fail++; $display("FAIL err_cleared got=err%b %h exp=err0 3f", e, p); end
    endtask

    task automatic test_backpressure();
        logic [63:0] p; logic e; int lat; bit ok; int bad;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        run_seq(a, b, p, e, lat, ok);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge ACLK); #1;
            if (m_prod !== 64'(a) * 64'(b) || s_ready !== 1'b0 || m_valid !== 1'b1) bad++;
        end
        n_checks++; if (!ok || bad !== 0) begin n_fail++; $display("FAIL backpressure_hold got=%0d bad cycles exp=0", bad); end
        finish_seq();
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL backpressure_release got=%b exp=1", s_ready); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] p; logic e; int lat; bit ok; int t;
        @(negedge ACLK);
        s_valid = 1; s_a = 32'd11; s_b = 32'd13;
        @(posedge ACLK);
        #1 s_valid = 0;
        t = 0;
        while (!(M_AXI_ARVALID && M_AXI_ARADDR == BASE + 32'h8) && t < 50) begin @(posedge ACLK); #1; t++; end
        n_checks++; if (t >= 50) begin n_fail++; $display("FAIL reach_rlo got=timeout exp=ARVALID at +8"); end
        ARESET = 1;
        #1;
        n_checks++; if ({M_AXI_ARVALID, M_AXI_RREADY, s_ready, m_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_mid got=%b exp=0000", {M_AXI_ARVALID, M_AXI_RREADY, s_ready, m_valid}); end
        @(negedge ACLK) ARESET = 0;
        #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_sready got=%b exp=1", s_ready); end
        run_seq(32'd6, 32'd7, p, e, lat, ok);
        finish_seq();
        n_checks++; if (!ok || p !== 64'd42 || e !== 1'b0 || lat !== LAT) begin n_fail++; $display("FAIL after_reset got=%h err%b lat%0d exp=2a err0 lat%0d", p, e, lat, LAT); end
    endtask

    task automatic test_random();
        logic [63:0] p; logic e; int lat; bit ok;
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = (i == 0) ? 32'd0 : $urandom;
            run_seq(a, b, p, e, lat, ok);
            finish_seq();
            n_checks++; if (!ok || p !== 64'(a) * 64'(b) || e !== 1'b0) begin n_fail++; $display("FAIL random_%0d got=%h err%b exp=%h err0", i, p, e, 64'(a) * 64'(b)); end
        end
    endtask

`ifdef MULT_AXIL_DRIVER_READBACK_EN
    task automatic test_readback_err();
        logic [63:0] p; logic e; int lat; bit ok;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        corrupt_b = 1;
        run_seq(a, b, p, e, lat, ok);
        finish_seq();
        corrupt_b = 0;
        n_checks++; if (!ok || e !== 1'b1 || p !== 64'(a) * 64'(b)) begin n_fail++; $display("FAIL readback_err got=err%b %h exp=err1 %h", e, p, 64'(a) * 64'(b)); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_max_addr_order();
        test_aw_delay();
        test_bresp_err();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef MULT_AXIL_DRIVER_READBACK_EN
        test_readback_err();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_axil_driver.md
MULT_AXIL_DRIVER -- requirements
Module: mult_axil_driver

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, the AXI4-Lite address width.
REQ-002 SHALL have parameter C_BASE_ADDR, default 32'h00000000, the base address of the multiplier register bank.
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port ARESET, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have operand-stream ports s_valid (in, 1), s_ready (out, 1), s_a (in, 32), s_b (in, 32).
REQ-006 SHALL have result-stream ports m_valid (out, 1), m_ready (in, 1), m_prod (out, 64), m_err (out, 1).
REQ-007 SHALL have the AW-channel ports M_AXI_AWADDR (out, C_M_AXI_ADDR_WIDTH), M_AXI_AWPROT (out, 3), M_AXI_AWVALID (out, 1) and M_AXI_AWREADY (in, 1).
REQ-008 SHALL have the W-channel ports M_AXI_WDATA (out, 32), M_AXI_WSTRB (out, 4), M_AXI_WVALID (out, 1) and M_AXI_WREADY (in, 1).
REQ-009 SHALL have the B-channel ports M_AXI_BRESP (in, 2), M_AXI_BVALID (in, 1) and M_AXI_BREADY (out, 1).
REQ-010 SHALL have the AR-channel ports M_AXI_ARADDR (out, C_M_AXI_ADDR_WIDTH), M_AXI_ARPROT (out, 3), M_AXI_ARVALID (out, 1) and M_AXI_ARREADY (in, 1).
REQ-011 SHALL have the R-channel ports M_AXI_RDATA (in, 32), M_AXI_RRESP (in, 2), M_AXI_RVALID (in, 1) and M_AXI_RREADY (out, 1).

Function
REQ-012 SHALL drive the multiplier slave register map: operand A at C_BASE_ADDR+0x0, operand B at +0x4, product low word at +0x8, product high word at +0xC.
REQ-013 SHALL drive AWPROT and ARPROT to 0 and WSTRB to 4'hF at all times.
REQ-014 SHALL implement the states IDLE, WA, WB, RLO, RHI and OUT, plus RA and RB only when the READBACK feature is enabled.
REQ-015 SHALL assert s_ready only in IDLE, and on an s_valid&s_ready edge SHALL capture s_a and s_b and enter WA.
REQ-016 SHALL, on entry to a write state (WA or WB), assert AWVALID and WVALID in the same cycle, carrying the captured operand and its address.
REQ-017 SHALL, in a write state, deassert AWVALID and WVALID each independently on its own handshake, with each presented exactly once per phase.
REQ-018 SHALL, in a write state, hold BREADY high after both AW and W handshakes, and SHALL leave the state on the BVALID&BREADY edge.
REQ-019 SHALL, on entry to a read state, assert ARVALID, hold it until ARREADY, then hold RREADY high, and SHALL leave the state on the RVALID&RREADY edge.
REQ-020 SHALL keep AWADDR, WDATA and ARADDR stable while their respective VALID is high.
REQ-021 SHALL use the state order IDLE->WA->WB->RLO->RHI->OUT, and SHALL load RDATA into m_prod[31:0] in RLO and into m_prod[63:32] in RHI.
REQ-022 SHALL clear m_err at the s handshake and SHALL set it sticky when any BRESP[1] or RRESP[1] is seen during the sequence; an error SHALL NOT abort the sequence.
REQ-023 SHALL assert m_valid in OUT, hold m_prod and m_err stable until the m_valid&m_ready edge, then return to IDLE.
REQ-024 SHALL NOT overlap sequences: a new operand pair is accepted only after the result handshake.
REQ-025 SHALL, with a zero-wait slave (READYs high, responses one cycle after handshake), make m_valid rise 8 clock edges after the s handshake edge, or 12 edges with READBACK enabled.

Reset
REQ-026 SHALL, while ARESET is high, immediately force: all AXI VALIDs 0, BREADY 0, RREADY 0, s_ready 0, m_valid 0, m_prod 0, m_err 0, and state IDLE.
REQ-027 SHALL, when ARESET is asserted mid-sequence, abort the sequence with no retry, and SHALL assert s_ready in the first cycle after ARESET falls.

Configuration
REQ-028 SHALL support the macro MULT_AXIL_DRIVER_READBACK_EN; when it is defined, states RA (read +0x0) and RB (read +0x4) SHALL be inserted between WB and RLO.
REQ-029 SHALL, with the macro defined, compare the RA and RB read data against the captured A and B, and set m_err on any mismatch.
REQ-030 SHALL, without the macro, contain no RA/RB logic or comparators.

Verification
REQ-031 Bench SHALL cover: zero-wait slave, A=3, B=5, slave multiplier -> m_prod=64'h0F, m_err=0, m_valid at edge 8 after handshake.
REQ-032 Bench SHALL cover: A=B=32'hFFFFFFFF -> m_prod=64'hFFFFFFFE_00000001, write addresses seen in order 0x0, 0x4 and read addresses in order 0x8, 0xC.
REQ-033 Bench SHALL cover: AWREADY delayed 3 cycles with WREADY immediate -> exactly one AW and one W handshake per write phase, with WVALID low after its handshake.
REQ-034 Bench SHALL cover: BRESP=2'b10 on the WB response -> sequence completes with m_err=1, and the next sequence starts with m_err cleared.
REQ-035 Bench SHALL cover: m_ready held low for 5 cycles in OUT -> m_prod stable and s_ready=0 throughout; ARESET pulsed during RLO -> ARVALID=0 and RREADY=0 in the same cycle, s_ready=1 after release.
REQ-036 Bench SHALL cover, with MULT_AXIL_DRIVER_READBACK_EN defined: slave returns 0xDEAD on the +0x4 readback -> m_err=1 while m_prod is still the read product.
